// File: rtl/dds_pkg.sv
// Constants shared by the DDS accumulator, the phase decoder and its bench.
package dds_pkg;
    localparam int PHASE_W     = 28;
    localparam int GATE_CYCLES = 10000;
    localparam int BASE_TUNE   = 26843;
    localparam int WRAP_W      = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_GATE = 2'd2,
        ST_CALC = 2'd3
    } dec_state_t;
endpackage

// File: rtl/phase_decoder.sv
// Measures phase advance over a gate window and rounds it back to the tuning value.
// IDLE: wait for en | ARM: capture start | GATE: track wraps, count gate | CALC: round, saturate, post
module phase_decoder #(
    parameter int PHASE_W     = dds_pkg::PHASE_W,
    parameter int GATE_CYCLES = dds_pkg::GATE_CYCLES,
    parameter int OUT_W       = 16
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               en,
    input  logic [PHASE_W-1:0] phase_in,
    output logic [OUT_W-1:0]   meas,
    output logic               meas_valid,
    output logic               busy
);
    import dds_pkg::*;

    localparam int ADV_W = PHASE_W + WRAP_W;
    localparam int RES_W = WRAP_W + 1;
    localparam int CNT_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [ADV_W:0]   HALF_LSB = (ADV_W + 1)'(1) << (PHASE_W - 1);
    localparam logic [RES_W-1:0] MAX_OUT  = (OUT_W >= RES_W) ? {RES_W{1'b1}}
                                          : RES_W'((64'd1 << OUT_W) - 64'd1);

    dec_state_t         r_state;
    logic [PHASE_W-1:0] r_start;
    logic [PHASE_W-1:0] r_prev;
    logic [PHASE_W-1:0] r_stop;
    logic [WRAP_W-1:0]  r_wraps;
    logic [CNT_W-1:0]   r_gate_cnt;

    logic               w_wrap;
    logic [ADV_W-1:0]   w_advance;
    logic [RES_W-1:0]   w_result;
    logic [RES_W-1:0]   w_sat;

    // Tuning words stay below 2^PHASE_W, so a drop in phase means exactly one wrap.
    assign w_wrap    = phase_in < r_prev;
    assign w_advance = {r_wraps, r_stop} - {{WRAP_W{1'b0}}, r_start};
    assign w_result  = RES_W'(({1'b0, w_advance} + HALF_LSB) >> PHASE_W);
    assign w_sat     = (w_result > MAX_OUT) ? MAX_OUT : w_result;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state    <= ST_IDLE;
            r_start    <= '0;
            r_prev     <= '0;
            r_stop     <= '0;
            r_wraps    <= '0;
            r_gate_cnt <= '0;
            meas       <= '0;
            meas_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (en) begin
                        r_state <= ST_ARM;
                        busy    <= 1'b1;
                    end
                end
                ST_ARM: begin
                    if (!en) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_start    <= phase_in;
                        r_prev     <= phase_in;
                        r_wraps    <= '0;
                        r_gate_cnt <= '0;
                        r_state    <= ST_GATE;
                    end
                end
                ST_GATE: begin
                    if (!en) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_prev     <= phase_in;
                        r_gate_cnt <= r_gate_cnt + CNT_W'(1);
                        if (w_wrap && (r_wraps != {WRAP_W{1'b1}}))
                            r_wraps <= r_wraps + WRAP_W'(1);
                        if (r_gate_cnt == CNT_W'(GATE_CYCLES - 1)) begin
                            r_stop  <= phase_in;
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    meas       <= OUT_W'(w_sat);
                    meas_valid <= 1'b1;
                    if (en) begin
                        r_state <= ST_ARM;
                    end else begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_phase_decoder.sv
// Scoreboard bench: free-running phase accumulators feed three decoder instances.
module tb_phase_decoder;
    localparam int            PW     = dds_pkg::PHASE_W;
    localparam int            G_A    = 1024;
    localparam int            G_B    = dds_pkg::GATE_CYCLES;
    localparam longint        TUNE_A = (longint'(1) << PW) / G_A;
    localparam longint        TUNE_B = dds_pkg::BASE_TUNE;
    localparam logic [PW-1:0] INC_C  = PW'(1) << (PW - 1);

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
    logic [PW-1:0] acc_a = '0, acc_b = '0, acc_c = '0;
    logic [PW-1:0] inc_a = '0, inc_b = '0;
    logic [PW-1:0] off_a = '0, off_b = '0;
    logic [PW-1:0] ph_a, ph_b, ph_c;
    logic [15:0]   meas_a, meas_b;
    logic [7:0]    meas_c;
    logic          mv_a, mv_b, mv_c;
    logic          busy_a, busy_b, busy_c;

    int     n_checks = 0;
    int     n_err    = 0;
    int     cyc      = 0;
    int     strobe_a = -1, strobe_b = -1, strobe_c = -1;
    longint done_a   = 0;
    longint q_a[$], q_b[$], q_c[$];

    phase_decoder #(.GATE_CYCLES(G_A), .OUT_W(16)) u_dut_a (
        .clk(clk), .clr(clr), .en(en_a), .phase_in(ph_a),
        .meas(meas_a), .meas_valid(mv_a), .busy(busy_a));
    phase_decoder #(.GATE_CYCLES(G_B), .OUT_W(16)) u_dut_b (
        .clk(clk), .clr(clr), .en(en_b), .phase_in(ph_b),
        .meas(meas_b), .meas_valid(mv_b), .busy(busy_b));
    phase_decoder #(.GATE_CYCLES(G_A), .OUT_W(8)) u_dut_c (
        .clk(clk), .clr(clr), .en(en_c), .phase_in(ph_c),
        .meas(meas_c), .meas_valid(mv_c), .busy(busy_c));

    always #5 clk = ~clk;

    // Offsets shift the start phase of a window without touching the per-clock step.
    assign ph_a = acc_a + off_a;
    assign ph_b = acc_b + off_b;
    assign ph_c = acc_c;

    initial forever begin
        @(posedge clk);
        #1;
        acc_a = acc_a + inc_a;
        acc_b = acc_b + inc_b;
        acc_c = acc_c + INC_C;
    end

    // Gate length times step, in turns of the phase circle, rounded to nearest.
    function automatic longint model(input longint gate, input longint inc, input int out_w);
        real    turns;
        longint nearest;
        longint top;
        turns   = real'(gate * inc) / (2.0 ** PW);
        nearest = longint'($floor(turns + 0.5));
        top     = (longint'(1) << out_w) - 1;
        return (nearest > top) ? top : nearest;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic bad_strobe(input string name, input longint act);
        n_checks++;
        n_err++;
        $display("FAIL %s: strobe with meas=%0d, expected no strobe", name, act);
    endtask

    initial forever begin
        @(negedge clk);
        cyc++;
        if (mv_a) begin
            strobe_a = cyc;
            if (q_a.size() == 0) bad_strobe("strobe_a", meas_a);
            else check("meas_a", meas_a, q_a.pop_front());
        end
        if (mv_b) begin
            strobe_b = cyc;
            if (q_b.size() == 0) bad_strobe("strobe_b", meas_b);
            else check("meas_b", meas_b, q_b.pop_front());
        end
        if (mv_c) begin
            strobe_c = cyc;
            if (q_c.size() == 0) bad_strobe("strobe_c", meas_c);
            else check("meas_c", meas_c, q_c.pop_front());
        end
    end

    task automatic start_a(input longint inc);
        inc_a = PW'(inc);
        off_a = PW'($urandom);
        q_a.push_back(model(G_A, inc, 16));
    endtask

    task automatic run_a(input longint inc, input int wait_n);
        longint e;
        start_a(inc);
        e = q_a[$];
        repeat (wait_n) @(negedge clk);
        #1;
        check("latency_a", strobe_a, cyc);
        done_a = e;
    endtask

    task automatic run_b(input longint inc, input int wait_n);
        inc_b = PW'(inc);
        off_b = PW'($urandom);
        q_b.push_back(model(G_B, inc, 16));
        repeat (wait_n) @(negedge clk);
        #1;
        check("latency_b", strobe_b, cyc);
    endtask

    task automatic proc_a();
        int seen;
        en_a = 1'b1;
        run_a(0, G_A + 3);
        run_a(0, G_A + 2);
        run_a(TUNE_A, G_A + 2);
        run_a(1023 * TUNE_A, G_A + 2);
        run_a(512 * TUNE_A, G_A + 2);
        for (int i = 0; i < 16; i++)
            run_a(longint'($urandom_range(0, 1023)) * TUNE_A, G_A + 2);
        for (int i = 0; i < 6; i++)
            run_a(longint'($urandom_range(0, 268435455)), G_A + 2);
        run_a(333 * TUNE_A, G_A + 2);

        start_a(longint'($urandom_range(1, 1023)) * TUNE_A);
        repeat (1 + G_A / 2) @(negedge clk);
        #1;
        check("busy_mid", busy_a, 1);
        en_a = 1'b0;
        void'(q_a.pop_back());
        seen = strobe_a;
        @(negedge clk);
        #1;
        check("abort_busy", busy_a, 0);
        check("abort_hold", meas_a, done_a);
        repeat (2 * G_A) @(negedge clk);
        #1;
        check("abort_quiet", strobe_a, seen);
        en_a = 1'b1;
        run_a(777 * TUNE_A, G_A + 3);
        en_a = 1'b0;
    endtask

    task automatic proc_b();
        en_b = 1'b1;
        run_b(TUNE_B, G_B + 3);
        run_b(1023 * TUNE_B, G_B + 2);
        run_b(512 * TUNE_B, G_B + 2);
        en_b = 1'b0;
    endtask

    task automatic proc_c();
        en_c = 1'b1;
        q_c.push_back(model(G_A, INC_C, 8));
        q_c.push_back(model(G_A, INC_C, 8));
        repeat (G_A + 3) @(negedge clk);
        #1;
        check("latency_c", strobe_c, cyc);
        repeat (G_A + 2) @(negedge clk);
        #1;
        check("period_c", strobe_c, cyc);
        en_c = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst_meas", meas_a, 0);
        check("rst_valid", mv_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_meas_c", meas_c, 0);
        clr = 1'b0;

        fork
            proc_a();
            proc_b();
            proc_c();
        join

        en_a = 1'b1;
        start_a(5 * TUNE_A);
        repeat (2 + 300) @(negedge clk);
        #1;
        clr = 1'b1;
        void'(q_a.pop_back());
        #1;
        check("clr_meas", meas_a, 0);
        check("clr_valid", mv_a, 0);
        check("clr_busy", busy_a, 0);
        check("clr_meas_b", meas_b, 0);
        @(negedge clk);
        #1;
        clr = 1'b0;
        run_a(900 * TUNE_A, G_A + 3);
        en_a = 1'b0;
        repeat (4) @(negedge clk);
        #1;

        check("drain_a", q_a.size(), 0);
        check("drain_b", q_b.size(), 0);
        check("drain_c", q_c.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
